// File: rtl/pipe_stage_reg_n_pkg.sv
// Shared types and helpers for the N-lane pipeline stage register.
// Holds the stage state encoding, the precise-kill lane mask rule and
// the lane slicing helper used when packing per-lane payloads.
package pipe_pkg;

   // Upper bound on issue width handled by the kill-mask helper.
   localparam int unsigned MAX_LANES = 32;

   // Occupancy of the stage: nothing held, head only, head plus skid.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } stage_state_e;

   // A lane survives only if it is valid and neither it nor any older lane
   // was killed; a kill therefore squashes the killed lane and everything
   // younger than it.
   function automatic logic [MAX_LANES-1:0] first_kill_mask(
      input logic [MAX_LANES-1:0] valid,
      input logic [MAX_LANES-1:0] kill
   );
      logic                 killed;
      logic [MAX_LANES-1:0] mask;
      killed = 1'b0;
      mask   = '0;
      for (int i = 0; i < MAX_LANES; i++) begin
         killed  = killed | kill[i];
         mask[i] = valid[i] & ~killed;
      end
      return mask;
   endfunction

   // Bit offset of a lane inside a flat lane-packed payload bus.
   function automatic int unsigned lane_lsb(
      input int unsigned lane,
      input int unsigned dw
   );
      return lane * dw;
   endfunction

endpackage

// File: rtl/pipe_stage_reg_n_slot.sv
// One bundle-wide storage register (payload, lane valids and sideband).
// Latency: one cycle from load to q.
// Backpressure: none; the owner decides when to load or clear.
module pipe_bundle_slot #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         clear,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] data_q;

   // Clear wins over load so a flush or drain never leaves stale bits behind.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q <= '0;
      end else if (clear) begin
         data_q <= '0;
      end else if (load) begin
         data_q <= d;
      end
   end

   assign q = data_q;

endmodule

// File: rtl/pipe_stage_reg_n.sv
// N-lane issue-bundle stage register with a one-bundle skid and registered in_ready.
// Latency: one cycle from accepted bundle to out_valid; one bundle per cycle sustained.
// Backpressure: out_ready low holds the head; second bundle goes to skid, then in_ready drops.
module pipe_stage_reg_n
   import pipe_pkg::*;
#(
   parameter int LANES = 2,
   parameter int DW    = 128,
   parameter int DBG_W = 97,
   parameter int CNT_W = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic [LANES-1:0]      in_valid,
   input  logic [LANES-1:0]      in_kill,
   input  logic [LANES*DW-1:0]   in_payload,
   input  logic [DBG_W-1:0]      in_dbg,
   output logic                  in_ready,
   output logic [LANES-1:0]      out_valid,
   output logic [LANES*DW-1:0]   out_payload,
   output logic [DBG_W-1:0]      out_dbg,
   input  logic                  out_ready,
   output logic [CNT_W-1:0]      stall_cnt
);

   localparam int PW = LANES * DW;
   localparam int SW = PW + LANES + DBG_W;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Slot layout, LSB first: payload, lane valids, sideband.
   logic [SW-1:0]    cap_bundle;
   logic [SW-1:0]    main_q;
   logic [SW-1:0]    skid_q;
   logic [SW-1:0]    main_d;

   logic [LANES-1:0] eff_valid;
   logic [PW-1:0]    cap_payload;

   stage_state_e     state_q;
   stage_state_e     state_d;
   logic             in_ready_q;
   logic [CNT_W-1:0] stall_cnt_q;

   logic             in_any;
   logic             in_fire;
   logic             cap_fire;
   logic             out_any;
   logic             out_fire;

   logic             main_load;
   logic             main_clear;
   logic             skid_load;
   logic             skid_clear;

   // Precise kill: drop the first killed lane and every younger lane.
   assign eff_valid = LANES'(first_kill_mask(MAX_LANES'(in_valid), MAX_LANES'(in_kill)));

   // Dropped lanes are stored as zero so invalid lanes never leak payload downstream.
   for (genvar i = 0; i < LANES; i++) begin : g_lane_mask
      assign cap_payload[lane_lsb(i, DW) +: DW] =
         eff_valid[i] ? in_payload[lane_lsb(i, DW) +: DW] : '0;
   end

   assign cap_bundle = {in_dbg, eff_valid, cap_payload};

   // Handshake terms; a fully killed bundle is accepted but not stored.
   assign in_any   = |in_valid;
   assign in_fire  = in_any & in_ready_q;
   assign cap_fire = in_fire & (|eff_valid);
   assign out_any  = |out_valid;
   assign out_fire = out_any & out_ready;

   // Next-state and storage control; flush overrides everything but rst.
   always_comb begin
      state_d    = state_q;
      main_d     = cap_bundle;
      main_load  = 1'b0;
      main_clear = 1'b0;
      skid_load  = 1'b0;
      skid_clear = 1'b0;
      if (flush) begin
         state_d    = EMPTY;
         main_clear = 1'b1;
         skid_clear = 1'b1;
      end else begin
         unique case (state_q)
            EMPTY: begin
               if (cap_fire) begin
                  main_load = 1'b1;
                  state_d   = ONE;
               end
            end
            ONE: begin
               if (cap_fire && out_fire) begin
                  main_load = 1'b1;
               end else if (cap_fire) begin
                  skid_load = 1'b1;
                  state_d   = TWO;
               end else if (out_fire) begin
                  main_clear = 1'b1;
                  state_d    = EMPTY;
               end
            end
            TWO: begin
               // in_ready is low here, so only draining the head can move us.
               if (out_fire) begin
                  main_d     = skid_q;
                  main_load  = 1'b1;
                  skid_clear = 1'b1;
                  state_d    = ONE;
               end
            end
            default: begin
               state_d    = EMPTY;
               main_clear = 1'b1;
               skid_clear = 1'b1;
            end
         endcase
      end
   end

   // State, registered in_ready and saturating stall counter (flush-immune).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= EMPTY;
         in_ready_q  <= 1'b1;
         stall_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= (state_d != TWO);
         if (out_any && !out_ready && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
         end
      end
   end

   pipe_bundle_slot #(
      .W (SW)
   ) u_main (
      .clk   (clk),
      .rst   (rst),
      .load  (main_load),
      .clear (main_clear),
      .d     (main_d),
      .q     (main_q)
   );

   pipe_bundle_slot #(
      .W (SW)
   ) u_skid (
      .clk   (clk),
      .rst   (rst),
      .load  (skid_load),
      .clear (skid_clear),
      .d     (cap_bundle),
      .q     (skid_q)
   );

   // Outputs come straight from the head register; the skid is never visible.
   assign out_payload = main_q[PW-1:0];
   assign out_valid   = main_q[PW +: LANES];
   assign out_dbg     = main_q[PW+LANES +: DBG_W];
   assign in_ready    = in_ready_q;
   assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg_n.sv
// Bench for pipe_stage_reg_n: directed scenarios followed by random traffic,
// all checked against a queue-based model of the stage (capacity two bundles).
module tb_pipe_stage_reg_n;

   localparam int LANES = 2;
   localparam int DW    = 32;
   localparam int DBG_W = 16;
   localparam int CNT_W = 4;
   localparam int PW    = LANES * DW;

   logic             clk = 1'b0;
   logic             rst;
   logic             flush;
   logic [LANES-1:0] in_valid;
   logic [LANES-1:0] in_kill;
   logic [PW-1:0]    in_payload;
   logic [DBG_W-1:0] in_dbg;
   logic             in_ready;
   logic [LANES-1:0] out_valid;
   logic [PW-1:0]    out_payload;
   logic [DBG_W-1:0] out_dbg;
   logic             out_ready;
   logic [CNT_W-1:0] stall_cnt;

   always #5 clk = ~clk;

   pipe_stage_reg_n #(
      .LANES (LANES),
      .DW    (DW),
      .DBG_W (DBG_W),
      .CNT_W (CNT_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_kill     (in_kill),
      .in_payload  (in_payload),
      .in_dbg      (in_dbg),
      .in_ready    (in_ready),
      .out_valid   (out_valid),
      .out_payload (out_payload),
      .out_dbg     (out_dbg),
      .out_ready   (out_ready),
      .stall_cnt   (stall_cnt)
   );

   typedef struct {
      logic [LANES-1:0] v;
      logic [PW-1:0]    p;
      logic [DBG_W-1:0] d;
   } bundle_t;

   bundle_t mq[$];
   bit      m_rdy;
   int      m_cnt;
   int      errors = 0;
   int      checks = 0;

   function automatic void model_reset();
      mq.delete();
      m_rdy = 1'b1;
      m_cnt = 0;
   endfunction

   // One clock edge of the stage as seen from outside: a FIFO of depth two.
   function automatic void model_edge();
      bundle_t b;
      bit      in_fire;
      bit      out_fire;
      bit      dead;
      in_fire  = (in_valid != '0) && m_rdy;
      out_fire = (mq.size() > 0) && out_ready;
      if ((mq.size() > 0) && !out_ready && (m_cnt < (1 << CNT_W) - 1)) m_cnt++;
      if (flush) begin
         mq.delete();
         m_rdy = 1'b1;
         return;
      end
      if (out_fire) void'(mq.pop_front());
      if (in_fire) begin
         dead = 1'b0;
         b.v  = '0;
         b.p  = '0;
         b.d  = in_dbg;
         for (int i = 0; i < LANES; i++) begin
            if (in_kill[i]) dead = 1'b1;
            if (in_valid[i] && !dead) begin
               b.v[i]           = 1'b1;
               b.p[i*DW +: DW]  = in_payload[i*DW +: DW];
            end
         end
         if (b.v != '0) mq.push_back(b);
      end
      m_rdy = (mq.size() < 2);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      logic [LANES-1:0] ev;
      logic [PW-1:0]    ep;
      logic [DBG_W-1:0] ed;
      ev = '0;
      ep = '0;
      ed = '0;
      if (mq.size() > 0) begin
         ev = mq[0].v;
         ep = mq[0].p;
         ed = mq[0].d;
      end
      chk({tag, ".out_valid"},   64'(out_valid),   64'(ev));
      chk({tag, ".out_payload"}, 64'(out_payload), 64'(ep));
      chk({tag, ".out_dbg"},     64'(out_dbg),     64'(ed));
      chk({tag, ".in_ready"},    64'(in_ready),    64'(m_rdy));
      chk({tag, ".stall_cnt"},   64'(stall_cnt),   64'(m_cnt));
   endtask

   task automatic drive(input logic [LANES-1:0] v, input logic [LANES-1:0] k,
                        input logic [PW-1:0] p, input logic [DBG_W-1:0] d);
      in_valid   = v;
      in_kill    = k;
      in_payload = p;
      in_dbg     = d;
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   // Reset asserted between edges: outputs must clear without waiting for a clock.
   task automatic async_reset(input string tag);
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      check_all(tag);
      chk({tag, ".imm_valid"}, 64'(out_valid), 64'd0);
      chk({tag, ".imm_ready"}, 64'(in_ready), 64'd1);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      flush     = 1'b0;
      out_ready = 1'b0;
      drive('0, '0, '0, '0);
      model_reset();
      #1;
      check_all("reset");
      #12;
      rst = 1'b0;
      check_all("post_reset");

      // Streaming at full rate.
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(2'b11, 2'b00, {32'h0000000B + 32'(i), 32'h0000000A + 32'(i)}, 16'(16'h100 + i));
         step("stream");
      end
      drive('0, '0, '0, '0);
      step("stream_drain");
      step("stream_idle");

      // Backpressure into the skid buffer.
      out_ready = 1'b0;
      drive(2'b11, 2'b00, {$urandom, $urandom}, 16'h0B01);
      step("bp_b1");
      drive(2'b11, 2'b00, {$urandom, $urandom}, 16'h0B02);
      step("bp_b2");
      chk("bp_two_ready", 64'(in_ready), 64'd0);
      drive(2'b11, 2'b00, {$urandom, $urandom}, 16'h0B03);
      step("bp_hold1");
      step("bp_hold2");
      drive('0, '0, '0, '0);
      out_ready = 1'b1;
      step("bp_drain1");
      step("bp_drain2");
      step("bp_drain3");
      chk("bp_ready_back", 64'(in_ready), 64'd1);

      // Precise kill.
      drive(2'b11, 2'b01, {$urandom, $urandom}, 16'h0C01);
      step("kill_lane0");
      chk("kill_lane0_empty", 64'(out_valid), 64'd0);
      drive(2'b11, 2'b10, {$urandom, $urandom}, 16'h0C02);
      step("kill_lane1");
      chk("kill_lane1_hi_zero", 64'(out_payload[DW +: DW]), 64'd0);
      drive('0, '0, '0, '0);
      step("kill_drain");

      // Flush while holding two bundles, then flush while in ONE with an input offered.
      out_ready = 1'b0;
      drive(2'b11, 2'b00, {$urandom, $urandom}, 16'h0D01);
      step("fl_b1");
      drive(2'b11, 2'b00, {$urandom, $urandom}, 16'h0D02);
      step("fl_b2");
      drive(2'b01, 2'b00, {$urandom, $urandom}, 16'h0D03);
      flush = 1'b1;
      step("flush_two");
      flush = 1'b0;
      chk("flush_two_payload", 64'(out_payload), 64'd0);
      drive(2'b11, 2'b00, {$urandom, $urandom}, 16'h0D04);
      step("fl_one");
      drive(2'b11, 2'b00, {$urandom, $urandom}, 16'h0D05);
      flush = 1'b1;
      out_ready = 1'b1;
      step("flush_one");
      flush = 1'b0;
      drive('0, '0, '0, '0);
      step("flush_after");

      // Counter saturation after a clean reset.
      async_reset("rst_before_sat");
      out_ready = 1'b0;
      drive(2'b11, 2'b00, {$urandom, $urandom}, 16'h0E01);
      step("sat_load");
      drive('0, '0, '0, '0);
      for (int i = 0; i < 20; i++) step("sat_block");
      chk("sat_value", 64'(stall_cnt), 64'd15);

      // Reset with a bundle held mid-transfer.
      drive(2'b11, 2'b00, {$urandom, $urandom}, 16'h0E02);
      step("rst_fill");
      async_reset("rst_mid");

      // Random traffic.
      for (int n = 0; n < 400; n++) begin
         drive(2'($urandom), ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00,
               {$urandom, $urandom}, 16'($urandom));
         out_ready = 1'($urandom);
         flush     = ($urandom_range(0, 15) == 0);
         step("rand");
      end
      flush = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
